// File: rtl/num_format_conv.sv
// num_format_conv
//   Two-stage pipelined converter between sign-magnitude (ZM), two's
//   complement (U2) and ones' complement (U1) for an m-bit operand. Each
//   result carries a 2-bit status. Valid/ready handshakes on both sides.
//
//   Optional feature macro: NUM_FORMAT_CONV_STATS_EN adds o_sat_cnt, a
//   saturating 16-bit count of accepted status-01 results.
//
// Ports
//   i_clk      rising-edge clock
//   i_rst_n    synchronous active-low reset
//   i_valid    operand valid
//   o_ready    converter can accept an operand this cycle
//   i_argA     operand (m bits)
//   i_mode     00 ZM->U2, 01 U2->ZM, 10 U1->U2, 11 U2->U1
//   o_valid    result valid
//   i_ready    consumer accepts the result
//   o_result   converted value (m bits)
//   o_status   00 OK, 01 saturated, 10 negative-zero input
//   o_sat_cnt  saturation event count (only with NUM_FORMAT_CONV_STATS_EN)
module num_format_conv #(
    parameter int m = 4,
    parameter int n = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [m-1:0] i_argA,
    input  logic [1:0]   i_mode,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [m-1:0] o_result,
    output logic [n-1:0] o_status
`ifdef NUM_FORMAT_CONV_STATS_EN
   ,output logic [15:0]  o_sat_cnt
`endif
);

    if (n != 2) begin : g_n_check
        $error("num_format_conv: parameter n must be 2");
    end
    if (m < 2) begin : g_m_check
        $error("num_format_conv: parameter m must be at least 2");
    end

    localparam logic [m-1:0] MIN_VAL  = {1'b1, {(m-1){1'b0}}};
    localparam logic [m-1:0] ALL_ONES = {m{1'b1}};
    localparam logic [m-1:0] ONE_VAL  = {{(m-1){1'b0}}, 1'b1};

    logic         s1_valid;
    logic [m-1:0] s1_arg;
    logic [1:0]   s1_mode;
    logic         s2_valid;
    logic [m-1:0] s2_result;
    logic [n-1:0] s2_status;

    logic         accept;
    logic         s1_adv;
    logic [m-1:0] conv_result;
    logic [n-1:0] conv_status;
    logic [m-1:0] mag_neg;
    logic [m-1:0] arg_neg;

    // A stage can take new data when it is empty or is being drained this cycle.
    assign o_ready  = !s1_valid || !s2_valid || i_ready;
    assign accept   = i_valid && o_ready;
    assign s1_adv   = s1_valid && (!s2_valid || i_ready);
    assign o_valid  = s2_valid;
    assign o_result = s2_result;
    assign o_status = s2_status;

    always_comb begin
        conv_result = s1_arg;
        conv_status = 2'b00;
        mag_neg     = '0 - {1'b0, s1_arg[m-2:0]};
        arg_neg     = '0 - s1_arg;
        if (s1_arg[m-1]) begin
            case (s1_mode)
                2'b00: begin
                    if (s1_arg == MIN_VAL) begin
                        conv_result = '0;
                        conv_status = 2'b10;
                    end else begin
                        conv_result = mag_neg;
                    end
                end
                2'b01: begin
                    // U2 minimum has no ZM magnitude; clamp to the most negative ZM.
                    if (s1_arg == MIN_VAL) begin
                        conv_result = ALL_ONES;
                        conv_status = 2'b01;
                    end else begin
                        conv_result = {1'b1, arg_neg[m-2:0]};
                    end
                end
                2'b10: begin
                    if (s1_arg == ALL_ONES) begin
                        conv_result = '0;
                        conv_status = 2'b10;
                    end else begin
                        conv_result = s1_arg + ONE_VAL;
                    end
                end
                default: begin
                    if (s1_arg == MIN_VAL) begin
                        conv_result = MIN_VAL;
                        conv_status = 2'b01;
                    end else begin
                        conv_result = s1_arg - ONE_VAL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid  <= 1'b0;
            s1_arg    <= '0;
            s1_mode   <= 2'b00;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_status <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_arg   <= i_argA;
                s1_mode  <= i_mode;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            // Result registers only load on an advance so they hold under back-pressure.
            if (s1_adv) begin
                s2_valid  <= 1'b1;
                s2_result <= conv_result;
                s2_status <= conv_status;
            end else if (i_ready) begin
                s2_valid  <= 1'b0;
            end
        end
    end

`ifdef NUM_FORMAT_CONV_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_sat_cnt <= '0;
        end else if (s2_valid && i_ready && (s2_status == 2'b01) && (o_sat_cnt != 16'hFFFF)) begin
            o_sat_cnt <= o_sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_num_format_conv.sv
module tb_num_format_conv;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_argA;
    logic [1:0] i_mode;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_result;
    logic [1:0] o_status;
`ifdef NUM_FORMAT_CONV_STATS_EN
    logic [15:0] sat_cnt;
`endif

    logic       v8;
    logic       rdy_out8;
    logic [7:0] a8;
    logic [1:0] md8;
    logic       ov8;
    logic       rdy8;
    logic [7:0] res8;
    logic [1:0] st8;
`ifdef NUM_FORMAT_CONV_STATS_EN
    logic [15:0] sat_cnt8;
`endif

    int checks = 0;
    int errors = 0;

    int q_r[$];
    int q_s[$];
    int sat_model = 0;
    bit hold_pending = 0;
    logic [3:0] held_r;
    logic [1:0] held_s;

    num_format_conv #(.m(4), .n(2)) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_argA(i_argA), .i_mode(i_mode), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_status(o_status)
`ifdef NUM_FORMAT_CONV_STATS_EN
       ,.o_sat_cnt(sat_cnt)
`endif
    );

    num_format_conv #(.m(8), .n(2)) u_dut8 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(v8), .o_ready(rdy_out8),
        .i_argA(a8), .i_mode(md8), .o_valid(ov8), .i_ready(rdy8),
        .o_result(res8), .o_status(st8)
`ifdef NUM_FORMAT_CONV_STATS_EN
       ,.o_sat_cnt(sat_cnt8)
`endif
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decode the operand to its integer value in the source format,
    // then encode that value in the target format.
    function automatic void ref_conv(input int w, input int a, input int md,
                                     output int r, output int st);
        int full = 1 << w;
        int half = 1 << (w - 1);
        int val;
        st = 0;
        r  = 0;
        case (md)
            0: begin
                val = (a >= half) ? -(a - half) : a;
                if (a == half) begin r = 0; st = 2; end
                else r = (val + full) % full;
            end
            1: begin
                val = (a >= half) ? a - full : a;
                if (val == -half) begin r = full - 1; st = 1; end
                else r = (val < 0) ? half + (-val) : val;
            end
            2: begin
                val = (a >= half) ? -((full - 1) - a) : a;
                if (a == full - 1) begin r = 0; st = 2; end
                else r = (val + full) % full;
            end
            default: begin
                val = (a >= half) ? a - full : a;
                if (val == -half) begin r = half; st = 1; end
                else r = (val < 0) ? (full - 1) + val : val;
            end
        endcase
    endfunction

    // One cycle: drive inputs at the falling edge, check just after, and update
    // the scoreboard with the handshakes that the next rising edge will perform.
    task automatic step(input logic v, input logic [3:0] a, input logic [1:0] md, input logic rdy);
        int er, es;
        i_valid = v;
        i_argA  = a;
        i_mode  = md;
        i_ready = rdy;
        #1;
        chk("o_ready", o_ready, (q_r.size() < 2) || rdy);
        if (q_r.size() == 0) chk("no_stale_valid", o_valid, 1'b0);
        if (hold_pending) begin
            chk("hold_valid", o_valid, 1'b1);
            chk("hold_result", o_result, held_r);
            chk("hold_status", o_status, held_s);
        end
`ifdef NUM_FORMAT_CONV_STATS_EN
        chk("sat_cnt", sat_cnt, sat_model);
`endif
        hold_pending = o_valid && !rdy;
        held_r = o_result;
        held_s = o_status;
        if (o_valid && rdy && q_r.size() > 0) begin
            er = q_r.pop_front();
            es = q_s.pop_front();
            chk("result", o_result, er);
            chk("status", o_status, es);
            if (es == 1 && sat_model < 65535) sat_model++;
        end
        if (v && o_ready) begin
            ref_conv(4, int'(a), int'(md), er, es);
            q_r.push_back(er);
            q_s.push_back(es);
        end
        @(negedge i_clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q_r.size() > 0; i++) step(1'b0, 4'($urandom), 2'($urandom), 1'b1);
        chk("drain_empty", q_r.size(), 0);
    endtask

    initial begin
        int er, es;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_argA  = '0;
        i_mode  = '0;
        i_ready = 1'b0;
        v8 = 1'b0; a8 = '0; md8 = '0; rdy8 = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_result", o_result, 4'h0);
        chk("rst_status", o_status, 2'b00);
        chk("rst_ready", o_ready, 1'b1);
`ifdef NUM_FORMAT_CONV_STATS_EN
        chk("rst_sat_cnt", sat_cnt, 16'h0);
`endif
        i_rst_n = 1'b1;

        // Latency: accepted at one edge, visible after the second.
        step(1'b1, 4'b1011, 2'b00, 1'b1);
        chk("lat_edge1_valid", o_valid, 1'b0);
        step(1'b0, 4'b0000, 2'b00, 1'b1);
        chk("lat_edge2_valid", o_valid, 1'b1);
        chk("lat_result", o_result, 4'b1101);
        drain();

        // Directed vectors, back to back.
        step(1'b1, 4'b1011, 2'b00, 1'b1);
        step(1'b1, 4'b1000, 2'b01, 1'b1);
        step(1'b1, 4'b1111, 2'b10, 1'b1);
        step(1'b1, 4'b1000, 2'b00, 1'b1);
        step(1'b1, 4'b1000, 2'b11, 1'b1);
        drain();

        // Every operand in every mode.
        for (int md = 0; md < 4; md++)
            for (int a = 0; a < 16; a++)
                step(1'b1, 4'(a), 2'(md), 1'b1);
        drain();

        // Back-pressure: 5 operands, consumer stalled for 3 cycles.
        step(1'b1, 4'b1000, 2'b01, 1'b0);
        step(1'b1, 4'b1110, 2'b00, 1'b0);
        step(1'b1, 4'b0011, 2'b10, 1'b0);
        chk("bp_full_ready", o_ready, 1'b0);
        step(1'b1, 4'b0011, 2'b10, 1'b1);
        step(1'b1, 4'b1001, 2'b11, 1'b1);
        step(1'b1, 4'b1111, 2'b10, 1'b1);
        drain();

        // Randomised traffic with random consumer stalls and idle cycles.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom),
                 $urandom_range(0, 3) != 0);
        drain();

        // Reset with both stages full: nothing in flight may ever appear.
        step(1'b1, 4'b1000, 2'b01, 1'b0);
        step(1'b1, 4'b1000, 2'b11, 1'b0);
        chk("pre_rst_full", o_ready, 1'b0);
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b0;
        @(negedge i_clk);
        chk("midrst_valid", o_valid, 1'b0);
        chk("midrst_ready", o_ready, 1'b1);
        chk("midrst_status", o_status, 2'b00);
        i_rst_n = 1'b1;
        q_r.delete();
        q_s.delete();
        sat_model = 0;
        hold_pending = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 4'b1000, 2'b01, 1'b1);
        step(1'b1, 4'b0101, 2'b01, 1'b1);
        drain();

        // Wider operand.
        v8 = 1'b1; a8 = 8'h85; md8 = 2'b11;
        @(negedge i_clk);
        a8 = 8'h80;
        @(negedge i_clk);
        v8 = 1'b0;
        ref_conv(8, 'h85, 3, er, es);
        chk("m8_valid_a", ov8, 1'b1);
        chk("m8_result_a", res8, er);
        chk("m8_status_a", st8, es);
        @(negedge i_clk);
        ref_conv(8, 'h80, 3, er, es);
        chk("m8_valid_b", ov8, 1'b1);
        chk("m8_result_b", res8, er);
        chk("m8_status_b", st8, es);
        @(negedge i_clk);
        chk("m8_idle", ov8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
